divremsqrt_iter_ctrl: RTL and testbench
=======================================

# divremsqrt_iter_ctrl

Iteration sequencer for the divide/remainder/square-root unit. It accepts a start request in the Execute stage, loads the operation's iteration count, and drives the digit-recurrence datapath one step per cycle. It ends the operation at the count limit or earlier when the residual-zero flag (`WZeroE`) from the early-termination block asserts. It then holds the result-valid state until the pipeline is not stalled, and owns the busy/stall signal the hazard unit uses for the whole operation.

## Interface
- `CW`, 7: iteration-counter width; supports up to 2^CW−1 iterations.
- `EARLYTERM`, 1: 1 = `WZeroE` may end iteration early; 0 = `WZeroE` ignored.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `StartE` input 1: request to begin a new operation; sampled only in IDLE.
- `SpecialCaseE` input 1: operands are special (NaN/inf/zero/div-by-zero); no iterations are run.
- `CyclesE` input CW: number of iterations for this operation; sampled with `StartE`.
- `WZeroE` input 1: residual-zero flag from the early-termination block; valid every BUSY cycle.
- `StallM` input 1: downstream stall; holds DONE.
- `FlushE` input 1: kill the in-flight operation.
- `LoadE` output 1: datapath load pulse for the operand/residual registers.
- `IterEnE` output 1: datapath iteration step enable.
- `BusyE` output 1: unit occupied; stalls the pipeline.
- `DoneM` output 1: result valid.
- `EarlyTermM` output 1: last operation ended via `WZeroE`.
- `IterCnt` output CW: remaining-iteration counter, for debug and verification.

## Operation
- States: IDLE, BUSY, DONE. A 2-bit encoded register.
- IDLE:
  - `Accept` = `StartE & ~FlushE`. `LoadE` = `Accept`, combinational, same cycle.
  - On `Accept` with `SpecialCaseE=1` or `CyclesE=0`: go to DONE and set `IterCnt`=0.
  - On `Accept` otherwise: go to BUSY and load `IterCnt`=`CyclesE`.
  - `EarlyTermM` clears on every `Accept`.
- BUSY:
  - `IterEnE`=1 every cycle.
  - `Term` = (`IterCnt`==1) | (`EARLYTERM` & `WZeroE`).
  - If `Term`: go to DONE. `IterCnt` ← 0.
  - If `Term` is due to `WZeroE` while `IterCnt`>1: set `EarlyTermM`=1.
  - Otherwise `IterCnt` ← `IterCnt`−1.
  - `StartE` is ignored in BUSY.
- DONE:
  - `DoneM`=1.
  - Stay while `StallM`=1; go to IDLE when `StallM`=0.
  - `StartE` is ignored in DONE. A new operation can be accepted the cycle after returning to IDLE.
- `FlushE` in any state:
  - Next state is IDLE, `IterCnt` ← 0, `IterEnE` forced to 0 that cycle.
  - `EarlyTermM` holds its value.
  - `FlushE` has priority over all other transitions.
- `BusyE` = (state==BUSY) | (IDLE & `Accept` & ~`SpecialCaseE` & `CyclesE`≠0).
  - Combinational, so the instruction behind the operation stalls from the start cycle.
  - DONE does not assert `BusyE`.
- `IterCnt` never decrements below 0. It has no wrap-around.

## Timing
- Reset, asynchronous:
  - State = IDLE, `IterCnt`=0, `EarlyTermM`=0.
  - `LoadE`=`IterEnE`=`DoneM`=0.
  - `BusyE`=0, unless `StartE` is asserted during deassertion.
  - Reset mid-operation drops the operation; no `DoneM` is produced.
- Latency for N=`CyclesE`≥1 with no early termination:
  - Start at cycle 0.
  - BUSY for cycles 1..N, with N `IterEnE` pulses.
  - `DoneM` from cycle N+1.
- Early termination: if `WZeroE`=1 in BUSY cycle k, cycle k is the last `IterEnE` and `DoneM` asserts in cycle k+1.
- Special case or `CyclesE`=0: `DoneM` in cycle 1, with zero `IterEnE` pulses.
- Minimum spacing between accepted starts: N+2 cycles (IDLE → BUSY×N → DONE → IDLE).

## Test plan
- Normal run, `CyclesE`=10, `WZeroE`=0:
  - `LoadE` pulses in cycle 0, followed by exactly 10 `IterEnE` cycles.
  - `DoneM` in cycle 11 with `EarlyTermM`=0.
  - Back to IDLE in cycle 12.
- Early termination, `CyclesE`=10, `WZeroE`=1 in BUSY cycle 4:
  - 4 `IterEnE` pulses, `DoneM` in cycle 5, `EarlyTermM`=1.
  - With `EARLYTERM`=0: 10 pulses and `EarlyTermM`=0.
- Special case, `StartE`+`SpecialCaseE`:
  - `BusyE`=0, `LoadE`=1, no `IterEnE`, `DoneM` in cycle 1.
  - `CyclesE`=0 behaves identically.
- Stall hold:
  - `StallM`=1 for 3 cycles on entering DONE: `DoneM` stays 1 for 4 cycles, then IDLE.
  - `StartE` held throughout: the next start is accepted only after DONE exits.
- Flush and reset mid-op:
  - `FlushE` in BUSY cycle 3 of 10: next cycle IDLE, `IterCnt`=0, no `DoneM`.
  - Asynchronous `reset` pulse mid-BUSY: outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/divremsqrt_iter_ctrl_if.sv
// Handshake bundle between the pipeline and the divide/remainder/sqrt
// iteration sequencer. The master side is the pipeline/test driver, the
// slave side is the sequencer itself.
interface divremsqrt_iter_ctrl_if #(
    parameter int CW = 7
);
    logic          StartE;
    logic          SpecialCaseE;
    logic [CW-1:0] CyclesE;
    logic          WZeroE;
    logic          StallM;
    logic          FlushE;
    logic          LoadE;
    logic          IterEnE;
    logic          BusyE;
    logic          DoneM;
    logic          EarlyTermM;
    logic [CW-1:0] IterCnt;

    modport master (
        output StartE, SpecialCaseE, CyclesE, WZeroE, StallM, FlushE,
        input  LoadE, IterEnE, BusyE, DoneM, EarlyTermM, IterCnt
    );

    modport slave (
        input  StartE, SpecialCaseE, CyclesE, WZeroE, StallM, FlushE,
        output LoadE, IterEnE, BusyE, DoneM, EarlyTermM, IterCnt
    );
endinterface

// File: rtl/divremsqrt_iter_ctrl.sv
// Iteration sequencer for the digit-recurrence divide/remainder/sqrt unit.
// Loads the iteration count on a start request, steps the datapath once per
// cycle, stops at the count limit or on residual-zero, then holds the
// result-valid state until the downstream stall clears.
module divremsqrt_iter_ctrl #(
    parameter int CW        = 7,
    parameter int EARLYTERM = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    divremsqrt_iter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] iter_cnt_reg;
    logic          early_reg;

    logic accept;
    logic zero_run;
    logic wz_hit;
    logic last_iter;
    logic term;

    // Start qualification and termination decode
    always_comb begin
        accept    = (state_reg == IDLE) & bus.StartE & ~bus.FlushE;
        zero_run  = bus.SpecialCaseE | (bus.CyclesE == '0);
        wz_hit    = (EARLYTERM != 0) & bus.WZeroE;
        last_iter = (iter_cnt_reg == CW'(1));
        term      = last_iter | wz_hit;
    end

    // Sequencer state, remaining-iteration counter and early-termination flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            iter_cnt_reg <= '0;
            early_reg    <= 1'b0;
        end else if (bus.FlushE) begin
            // Flush wins over everything; the early flag keeps its history.
            state_reg    <= IDLE;
            iter_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        early_reg <= 1'b0;
                        if (zero_run) begin
                            state_reg    <= DONE;
                            iter_cnt_reg <= '0;
                        end else begin
                            state_reg    <= BUSY;
                            iter_cnt_reg <= bus.CyclesE;
                        end
                    end
                end
                BUSY: begin
                    if (term) begin
                        state_reg    <= DONE;
                        iter_cnt_reg <= '0;
                        // Only a residual-zero stop before the natural last
                        // step counts as an early termination.
                        if (wz_hit && (iter_cnt_reg > CW'(1))) begin
                            early_reg <= 1'b1;
                        end
                    end else if (iter_cnt_reg != '0) begin
                        iter_cnt_reg <= iter_cnt_reg - CW'(1);
                    end
                end
                DONE: begin
                    if (!bus.StallM) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    iter_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Output decode; BusyE asserts in the start cycle so the trailing
    // instruction stalls immediately.
    always_comb begin
        bus.LoadE      = accept;
        bus.IterEnE    = (state_reg == BUSY) & ~bus.FlushE;
        bus.BusyE      = (state_reg == BUSY) | (accept & ~zero_run);
        bus.DoneM      = (state_reg == DONE);
        bus.EarlyTermM = early_reg;
        bus.IterCnt    = iter_cnt_reg;
    end
endmodule

// File: tb/tb_divremsqrt_iter_ctrl.sv
// Directed bench for the iteration sequencer. Two instances run side by side
// on identical stimulus: one with early termination enabled, one without.
module tb_divremsqrt_iter_ctrl;
    logic       clk;
    logic       reset;
    logic       start;
    logic       spec_case;
    logic [6:0] cycles;
    logic       wz;
    logic       flush;
    logic       stall_v [2];

    int checks = 0;
    int errors = 0;

    divremsqrt_iter_ctrl_if #(.CW(7)) bus0 ();
    divremsqrt_iter_ctrl_if #(.CW(7)) bus1 ();

    assign bus0.StartE       = start;
    assign bus0.SpecialCaseE = spec_case;
    assign bus0.CyclesE      = cycles;
    assign bus0.WZeroE       = wz;
    assign bus0.FlushE       = flush;
    assign bus0.StallM       = stall_v[0];
    assign bus1.StartE       = start;
    assign bus1.SpecialCaseE = spec_case;
    assign bus1.CyclesE      = cycles;
    assign bus1.WZeroE       = wz;
    assign bus1.FlushE       = flush;
    assign bus1.StallM       = stall_v[1];

    // index 0: EARLYTERM=0, index 1: EARLYTERM=1
    logic       load_v   [2];
    logic       iteren_v [2];
    logic       busy_v   [2];
    logic       done_v   [2];
    logic       early_v  [2];
    logic [6:0] cnt_v    [2];

    assign load_v[0]   = bus0.LoadE;
    assign iteren_v[0] = bus0.IterEnE;
    assign busy_v[0]   = bus0.BusyE;
    assign done_v[0]   = bus0.DoneM;
    assign early_v[0]  = bus0.EarlyTermM;
    assign cnt_v[0]    = bus0.IterCnt;
    assign load_v[1]   = bus1.LoadE;
    assign iteren_v[1] = bus1.IterEnE;
    assign busy_v[1]   = bus1.BusyE;
    assign done_v[1]   = bus1.DoneM;
    assign early_v[1]  = bus1.EarlyTermM;
    assign cnt_v[1]    = bus1.IterCnt;

    divremsqrt_iter_ctrl #(.CW(7), .EARLYTERM(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    divremsqrt_iter_ctrl #(.CW(7), .EARLYTERM(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation on both instances. Cycle 0 is the start cycle; the run
    // ends when each instance has left DONE. ep/ee are the expected IterEnE
    // pulse count and EarlyTermM per instance.
    task automatic run_op(input string tag, input logic [6:0] n, input bit sc,
                          input int wz_k, input int stall_n, input bit hold,
                          input bit eb, input int ep0, input int ee0,
                          input int ep1, input int ee1);
        int p    [2];
        int dcyc [2];
        int dlen [2];
        int ev   [2];
        bit seen [2];
        bit fin  [2];
        int ep   [2];
        int ee   [2];
        ep = '{ep0, ep1};
        ee = '{ee0, ee1};
        for (int d = 0; d < 2; d++) begin
            p[d] = 0; dcyc[d] = -1; dlen[d] = 0; ev[d] = -1;
            seen[d] = 1'b0; fin[d] = 1'b0;
        end
        @(negedge clk);
        start = 1'b1; spec_case = sc; cycles = n; wz = 1'b0; flush = 1'b0;
        stall_v[0] = 1'b0; stall_v[1] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check({tag, ":load"}, 32'(load_v[d]), 32'd1);
            check({tag, ":busy_start"}, 32'(busy_v[d]), 32'(eb));
            check({tag, ":iteren_start"}, 32'(iteren_v[d]), 32'd0);
        end
        for (int c = 1; c <= 60 && !(fin[0] && fin[1]); c++) begin
            @(negedge clk);
            start = hold;
            wz    = (c == wz_k);
            for (int d = 0; d < 2; d++) begin
                stall_v[d] = done_v[d] && (dlen[d] < stall_n);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                if (!fin[d]) begin
                    if (iteren_v[d]) begin
                        check({tag, ":cnt"}, 32'(cnt_v[d]), 32'(n) - 32'(p[d]));
                        check({tag, ":busy_run"}, 32'(busy_v[d]), 32'd1);
                        check({tag, ":noload_busy"}, 32'(load_v[d]), 32'd0);
                        p[d]++;
                    end else if (done_v[d]) begin
                        if (!seen[d]) begin
                            seen[d] = 1'b1;
                            dcyc[d] = c;
                            ev[d]   = int'(early_v[d]);
                        end
                        dlen[d]++;
                        check({tag, ":noload_done"}, 32'(load_v[d]), 32'd0);
                        check({tag, ":busy_done"}, 32'(busy_v[d]), 32'd0);
                    end else if (seen[d]) begin
                        fin[d] = 1'b1;
                        check({tag, ":idle_load"}, 32'(load_v[d]), 32'(hold));
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            check({tag, ":finished"}, 32'(fin[d]), 32'd1);
            check({tag, ":pulses"}, 32'(p[d]), 32'(ep[d]));
            check({tag, ":done_cycle"}, 32'(dcyc[d]), 32'(ep[d] + 1));
            check({tag, ":done_len"}, 32'(dlen[d]), 32'(stall_n + 1));
            check({tag, ":early"}, 32'(ev[d]), 32'(ee[d]));
        end
        $display("OP %s n=%0d sc=%0d wz_k=%0d stall=%0d | et0 pulses=%0d done@%0d early=%0d | et1 pulses=%0d done@%0d early=%0d",
                 tag, n, sc, wz_k, stall_n, p[0], dcyc[0], ev[0], p[1], dcyc[1], ev[1]);
        // Kill anything a held start may have launched; flush leaves the early flag alone.
        @(negedge clk);
        start = 1'b0; wz = 1'b0; flush = 1'b1;
        stall_v[0] = 1'b0; stall_v[1] = 1'b0;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        int dn;
        reset = 1'b1; start = 1'b0; spec_case = 1'b0; cycles = '0;
        wz = 1'b0; flush = 1'b0; stall_v[0] = 1'b0; stall_v[1] = 1'b0;
        #3;
        check("reset:cnt", 32'(cnt_v[1]), 32'd0);
        check("reset:done", 32'(done_v[1]), 32'd0);
        check("reset:busy", 32'(busy_v[1]), 32'd0);
        check("reset:early", 32'(early_v[1]), 32'd0);
        check("reset:iteren", 32'(iteren_v[1]), 32'd0);
        check("reset:load", 32'(load_v[1]), 32'd0);
        $display("OP reset cnt=%0d done=%0d busy=%0d", cnt_v[1], done_v[1], busy_v[1]);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        //     tag        n    sc wz_k stall hold eb  ep0 ee0 ep1 ee1
        run_op("normal",  10, 0,  0,   0,    0,   1,  10, 0,  10, 0);
        run_op("early",   10, 0,  4,   0,    0,   1,  10, 0,  4,  1);
        run_op("special", 10, 1,  0,   0,    0,   0,  0,  0,  0,  0);
        run_op("zerocyc", 0,  0,  0,   0,    0,   0,  0,  0,  0,  0);
        run_op("stall",   5,  0,  0,   3,    1,   1,  5,  0,  5,  0);
        run_op("wz_last", 3,  0,  3,   0,    0,   1,  3,  0,  3,  0);
        run_op("one",     1,  0,  0,   0,    0,   1,  1,  0,  1,  0);

        // Flush in BUSY cycle 3 of 10
        @(negedge clk);
        start = 1'b1; spec_case = 1'b0; cycles = 7'd10;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (c == 3);
        end
        #1;
        check("flush:iteren_forced", 32'(iteren_v[1]), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush:cnt", 32'(cnt_v[1]), 32'd0);
        check("flush:busy", 32'(busy_v[1]), 32'd0);
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_v[1] || done_v[0]) dn++;
            @(negedge clk);
            #1;
        end
        check("flush:no_done", 32'(dn), 32'd0);
        $display("OP flush_busy cnt=%0d done_seen=%0d", cnt_v[1], dn);

        // Flush while DONE is stalled: early flag must survive
        @(negedge clk);
        start = 1'b1; cycles = 7'd2;
        @(negedge clk);
        start = 1'b0; wz = 1'b1;
        @(negedge clk);
        wz = 1'b0; stall_v[0] = 1'b1; stall_v[1] = 1'b1;
        #1;
        check("flushdone:done", 32'(done_v[1]), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; stall_v[0] = 1'b0; stall_v[1] = 1'b0;
        #1;
        check("flushdone:idle", 32'(done_v[1]), 32'd0);
        check("flushdone:early_held", 32'(early_v[1]), 32'd1);
        $display("OP flush_done done=%0d early=%0d", done_v[1], early_v[1]);

        // Asynchronous reset mid-BUSY
        @(negedge clk);
        start = 1'b1; cycles = 7'd10;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check("areset:busy_before", 32'(busy_v[1]), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("areset:busy", 32'(busy_v[1]), 32'd0);
        check("areset:iteren", 32'(iteren_v[1]), 32'd0);
        check("areset:cnt", 32'(cnt_v[1]), 32'd0);
        check("areset:done", 32'(done_v[1]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            #1;
            if (done_v[1] || done_v[0]) dn++;
        end
        check("areset:no_done", 32'(dn), 32'd0);
        $display("OP async_reset cnt=%0d done_seen=%0d", cnt_v[1], dn);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
